// File: rtl/intcode_sequencer_if.sv
// Single-port memory bus between intcode_sequencer (master) and the memory block (slave).
interface intcode_sequencer_if #(
  parameter int AddressSize = 8,
  parameter int WordSize    = 64
);
  logic [AddressSize-1:0] mem_address;
  logic [WordSize-1:0]    mem_write_data;
  logic                   mem_write_enable;
  logic [WordSize-1:0]    mem_read_data;

  modport master (
    output mem_address,
    output mem_write_data,
    output mem_write_enable,
    input  mem_read_data
  );

  modport slave (
    input  mem_address,
    input  mem_write_data,
    input  mem_write_enable,
    output mem_read_data
  );
endinterface

// File: rtl/intcode_sequencer.sv
// Intcode (add/mul/halt) control FSM driving one single-port memory, one access per clock.
// Optional INTCODE_INSTR_COUNT_EN adds a saturating instr_count output.
module intcode_sequencer #(
  parameter int AddressSize = 8,
  parameter int WordSize    = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  intcode_sequencer_if.master    mem,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             error_code,
  output logic [WordSize-1:0]    result,
  output logic [AddressSize-1:0] pc
`ifdef INTCODE_INSTR_COUNT_EN
  ,
  output logic [31:0]            instr_count
`endif
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH_OP = 4'd1;
  localparam logic [3:0] S_FETCH_A  = 4'd2;
  localparam logic [3:0] S_FETCH_B  = 4'd3;
  localparam logic [3:0] S_FETCH_C  = 4'd4;
  localparam logic [3:0] S_LOAD_A   = 4'd5;
  localparam logic [3:0] S_LOAD_B   = 4'd6;
  localparam logic [3:0] S_WRITE    = 4'd7;
  localparam logic [3:0] S_READ_RES = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;
  localparam logic [3:0] S_ERROR    = 4'd10;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_OPCODE = 2'd1;
  localparam logic [1:0] ERR_PTR    = 2'd2;
  localparam logic [1:0] ERR_PC     = 2'd3;

  // Highest pc whose three operand words still fit in memory: 2^AddressSize-4.
  localparam logic [AddressSize-1:0] PC_LAST = ~AddressSize'(3);

  logic [3:0]             state_q, state_d;
  logic [AddressSize-1:0] pc_q, pc_d;
  logic                   mul_q, mul_d;
  logic [AddressSize-1:0] ptra_q, ptra_d;
  logic [AddressSize-1:0] ptrb_q, ptrb_d;
  logic [AddressSize-1:0] ptrc_q, ptrc_d;
  logic [WordSize-1:0]    vala_q, vala_d;
  logic [WordSize-1:0]    valb_q, valb_d;
  logic [WordSize-1:0]    result_q, result_d;
  logic [1:0]             err_q, err_d;

  logic [WordSize-1:0]    rd;
  logic                   ptr_bad;
  logic [AddressSize:0]   pc_inc;
  logic [WordSize-1:0]    alu;
  logic                   start_accept;

  assign rd           = mem.mem_read_data;
  assign ptr_bad      = |(rd >> AddressSize);
  assign pc_inc       = {1'b0, pc_q} + (AddressSize + 1)'(4);
  assign alu          = mul_q ? (vala_q * valb_q) : (vala_q + valb_q);
  assign busy         = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign start_accept = start && !busy;
  assign error_code   = err_q;
  assign result       = result_q;
  assign pc           = pc_q;

  // Write enable is gated by reset so an aborted WRITE never reaches the negedge.
  assign mem.mem_write_enable = (state_q == S_WRITE) && !reset;
  assign mem.mem_write_data   = (state_q == S_WRITE) ? alu : '0;

  always_comb begin
    mem.mem_address = '0;
    case (state_q)
      S_FETCH_OP: mem.mem_address = pc_q;
      S_FETCH_A:  mem.mem_address = pc_q + AddressSize'(1);
      S_FETCH_B:  mem.mem_address = pc_q + AddressSize'(2);
      S_FETCH_C:  mem.mem_address = pc_q + AddressSize'(3);
      S_LOAD_A:   mem.mem_address = ptra_q;
      S_LOAD_B:   mem.mem_address = ptrb_q;
      S_WRITE:    mem.mem_address = ptrc_q;
      default:    mem.mem_address = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mul_d    = mul_q;
    ptra_d   = ptra_q;
    ptrb_d   = ptrb_q;
    ptrc_d   = ptrc_q;
    vala_d   = vala_q;
    valb_d   = valb_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_FETCH_OP;
          pc_d    = '0;
          err_d   = ERR_NONE;
        end
      end
      S_FETCH_OP: begin
        if ((rd == WordSize'(1)) || (rd == WordSize'(2))) begin
          mul_d = (rd == WordSize'(2));
          if (pc_q > PC_LAST) begin
            state_d = S_ERROR;
            err_d   = ERR_PC;
          end else begin
            state_d = S_FETCH_A;
          end
        end else if (rd == WordSize'(99)) begin
          state_d = S_READ_RES;
        end else begin
          state_d = S_ERROR;
          err_d   = ERR_OPCODE;
        end
      end
      S_FETCH_A, S_FETCH_B, S_FETCH_C: begin
        if (ptr_bad) begin
          state_d = S_ERROR;
          err_d   = ERR_PTR;
        end else if (state_q == S_FETCH_A) begin
          ptra_d  = rd[AddressSize-1:0];
          state_d = S_FETCH_B;
        end else if (state_q == S_FETCH_B) begin
          ptrb_d  = rd[AddressSize-1:0];
          state_d = S_FETCH_C;
        end else begin
          ptrc_d  = rd[AddressSize-1:0];
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        vala_d  = rd;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        valb_d  = rd;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        pc_d = pc_inc[AddressSize-1:0];
        if (pc_inc[AddressSize]) begin
          state_d = S_ERROR;
          err_d   = ERR_PC;
        end else begin
          state_d = S_FETCH_OP;
        end
      end
      S_READ_RES: begin
        result_d = rd;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      mul_q    <= 1'b0;
      ptra_q   <= '0;
      ptrb_q   <= '0;
      ptrc_q   <= '0;
      vala_q   <= '0;
      valb_q   <= '0;
      result_q <= '0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      mul_q    <= mul_d;
      ptra_q   <= ptra_d;
      ptrb_q   <= ptrb_d;
      ptrc_q   <= ptrc_d;
      vala_q   <= vala_d;
      valb_q   <= valb_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

`ifdef INTCODE_INSTR_COUNT_EN
  logic [31:0] icnt_q, icnt_d;

  always_comb begin
    icnt_d = icnt_q;
    if (start_accept)
      icnt_d = '0;
    else if ((state_q == S_WRITE) && (icnt_q != '1))
      icnt_d = icnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) icnt_q <= '0;
    else       icnt_q <= icnt_d;
  end

  assign instr_count = icnt_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule
